// File: rtl/ef_smsdac8_dec.sv
// ----------------------------------------------------------------------------
// ef_smsdac8_dec
//
// Receive-side decoder and checker for the 8-b segmented mismatch-shaping DAC
// encoder. The 14-bit element-drive word (seven 3-level elements with weights
// 1x..64x) is reduced back to its equivalent 8-b code. That code is compared
// against a delayed copy of the stimulus reference, and mismatches are counted.
//
// Optional build macro: EF_SMSDAC_DEC_IMB_MON_EN
//   defined   - per-element imbalance accumulators and sticky o_imb_err flags
//   undefined - no accumulators; o_imb_err tied to 0; i_mon_en ignored
//
// Parameters
//   LAT    cycles from a code on i_ref to the matching word on i_y (1..15)
//   CNT_W  width of the saturating sample / error counters
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset, clears every register
//   i_y        element word {y64[1:0], y32[1:0], ..., y1[1:0]}
//   i_y_vld    i_y valid this cycle
//   i_ref      expected code
//   i_ref_vld  i_ref valid this cycle
//   i_mon_en   imbalance monitor enable
//   i_clr      synchronous clear of counters, accumulators and sticky flags
//   o_d        decoded code (registered)
//   o_d_vld    o_d valid
//   o_mis      one-cycle pulse on a failed compare
//   o_err_cnt  saturating mismatch count
//   o_smp_cnt  saturating compared-sample count
//   o_imb_err  sticky per-element imbalance flag, bit k is weight 2^k
// ----------------------------------------------------------------------------
module ef_smsdac8_dec #(
   parameter int LAT   = 4,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [13:0]      i_y,
   input  logic             i_y_vld,
   input  logic [7:0]       i_ref,
   input  logic             i_ref_vld,
   input  logic             i_mon_en,
   input  logic             i_clr,
   output logic [7:0]       o_d,
   output logic             o_d_vld,
   output logic             o_mis,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_smp_cnt,
   output logic [6:0]       o_imb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [7:0] dec_sum;
   logic [8:0] dly [LAT];
   logic [7:0] ref_s1;
   logic       ref_vld_s1;
   logic       cmp_s1;
   logic       neq_s1;

   // Each element contributes 0, 1 or 2 times its binary weight. The largest
   // reachable sum is 2*127 = 254, so an 8-bit accumulation never overflows
   // and the ninth bit of the full-width sum is always zero.
   always_comb begin
      dec_sum = '0;
      for (int k = 0; k < 7; k++) begin
         dec_sum = dec_sum + (({7'd0, i_y[2*k+1]} + {7'd0, i_y[2*k]}) << k);
      end
   end

   // Reference delay line: shifts every cycle, so the tail entry during cycle
   // n holds the reference presented in cycle n-LAT, lining it up with i_y.
   // i_clr deliberately leaves it alone so a clear never misaligns the stream.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < LAT; i++) begin
            dly[i] <= '0;
         end
      end else begin
         dly[0] <= {i_ref_vld, i_ref};
         for (int i = 1; i < LAT; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   // Stage 1: register the decoded code and carry the aligned reference along
   // with it so both arrive at the comparator in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_d        <= '0;
         o_d_vld    <= 1'b0;
         ref_s1     <= '0;
         ref_vld_s1 <= 1'b0;
      end else begin
         o_d        <= dec_sum;
         o_d_vld    <= i_y_vld;
         ref_s1     <= dly[LAT-1][7:0];
         ref_vld_s1 <= dly[LAT-1][8];
      end
   end

   assign cmp_s1 = o_d_vld & ref_vld_s1;
   assign neq_s1 = cmp_s1 & (o_d != ref_s1);

   // Stage 2: compare and count. Clear takes priority over any compare that
   // completes in the same cycle; counters hold at all-ones instead of
   // wrapping, while o_mis keeps pulsing on every failed compare.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mis     <= 1'b0;
         o_err_cnt <= '0;
         o_smp_cnt <= '0;
      end else if (i_clr) begin
         o_mis     <= 1'b0;
         o_err_cnt <= '0;
         o_smp_cnt <= '0;
      end else begin
         o_mis <= neq_s1;
         if (cmp_s1 && (o_smp_cnt != CNT_MAX)) begin
            o_smp_cnt <= o_smp_cnt + 1'b1;
         end
         if (neq_s1 && (o_err_cnt != CNT_MAX)) begin
            o_err_cnt <= o_err_cnt + 1'b1;
         end
      end
   end

`ifdef EF_SMSDAC_DEC_IMB_MON_EN

   logic signed [3:0] imb_acc [7];
   logic              imb_upd_s1;
   logic [6:0]        imb_err_q;

   // One saturating step of an element accumulator: +1 when only the upper
   // half of the element is driven, -1 when only the lower half is, else hold.
   function automatic logic signed [3:0] acc_step(input logic signed [3:0] acc,
                                                  input logic              up,
                                                  input logic              dn);
      logic signed [3:0] res;
      res = acc;
      if (up && !dn && (acc != 4'sd7)) begin
         res = acc + 4'sd1;
      end else if (dn && !up && (acc != -4'sd8)) begin
         res = acc - 4'sd1;
      end
      return res;
   endfunction

   // Imbalance monitor. The accumulators update in the cycle after the sample,
   // and the flag check runs one cycle later on the updated value, but only
   // when that value came from a real update (imb_upd_s1). Holding i_mon_en
   // low freezes the accumulators and blocks new flags.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         for (int k = 0; k < 7; k++) begin
            imb_acc[k] <= '0;
         end
         imb_upd_s1 <= 1'b0;
         imb_err_q  <= '0;
      end else begin
         imb_upd_s1 <= i_y_vld & i_mon_en;
         if (i_y_vld && i_mon_en) begin
            for (int k = 0; k < 7; k++) begin
               imb_acc[k] <= acc_step(imb_acc[k], i_y[2*k+1], i_y[2*k]);
            end
         end
         if (imb_upd_s1) begin
            for (int k = 0; k < 7; k++) begin
               if ((imb_acc[k] > 4'sd1) || (imb_acc[k] < -4'sd1)) begin
                  imb_err_q[k] <= 1'b1;
               end
            end
         end
      end
   end

   assign o_imb_err = imb_err_q;

`else

   logic mon_en_unused;

   // Monitor not built: the enable input has no effect.
   assign mon_en_unused = i_mon_en;
   assign o_imb_err     = '0;

`endif

endmodule
